// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing the register file's single 64-bit read port among NREQ requesters,
// with a registered, backpressured response.
module regfile_read_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned IDW      = $clog2(NREQ),
  parameter bit          ZERO_R31 = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  output logic [4:0]        port_sel,
  input  logic [63:0]       port_data,
  output logic              rsp_valid,
  output logic [63:0]       rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic [4:0]        rsp_addr,
  input  logic              rsp_ready
);

  logic [IDW-1:0] rr_ptr_q;
  logic           rsp_valid_q;
  logic [63:0]    rsp_data_q;
  logic [IDW-1:0] rsp_id_q;
  logic [4:0]     rsp_addr_q;

  logic           can_issue;
  logic           any_valid;
  logic           grant;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] rr_ptr_next;

  assign can_issue = !rsp_valid_q || rsp_ready;
  // Gated by reset so no handshake can complete while the response register is held clear.
  assign grant     = reset_n && can_issue && any_valid;

  // First valid requester scanning upward from rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    any_valid = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!any_valid && req_valid[IDW'(idx)]) begin
        any_valid = 1'b1;
        winner    = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    port_sel  = 5'd0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant && (winner == IDW'(i))) begin
        req_ready[i] = 1'b1;
        port_sel     = req_addr[5*i +: 5];
      end
    end
  end

  assign rr_ptr_next = (32'(winner) == NREQ - 1) ? '0 : winner + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_addr_q  <= '0;
    end else if (grant) begin
      rr_ptr_q    <= rr_ptr_next;
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= (ZERO_R31 && (port_sel == 5'd31)) ? 64'h0 : port_data;
      rsp_id_q    <= winner;
      rsp_addr_q  <= port_sel;
    end else if (can_issue) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_addr  = rsp_addr_q;

endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Shares the single 64-bit read port of the register file (the 32-to-1 read mux driven by a 5-bit select) among NREQ requesters. It uses round-robin arbitration with a valid/ready handshake on each request. It captures the mux output into a registered response with backpressure. It sits between the read-port mux and the pipeline stages and debug/test clients that need register reads.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), width of requester ID
- ZERO_R31, 1, when 1 a read of address 31 returns 64'h0 (XZR semantics); when 0 it returns port_data

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request i pending
- req_addr  in  5*NREQ  requester i address at [5i+4:5i]
- req_ready  out  NREQ  one-hot grant, combinational; handshake completes when req_valid[i] & req_ready[i]
- port_sel  out  5  select to read-port mux, combinational
- port_data  in  64  read-port mux output, combinational from port_sel
- rsp_valid  out  1  response register holds valid data
- rsp_data  out  64  read data
- rsp_id  out  IDW  index of requester that owns the response
- rsp_addr  out  5  address that was read
- rsp_ready  in  1  consumer accepts response this cycle

## Operation
- State: rr_ptr (IDW bits, next-highest-priority requester), response register {rsp_valid, rsp_data, rsp_id, rsp_addr}.
- can_issue = !rsp_valid | rsp_ready.
- Winner: the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … modulo NREQ.
- Grant occurs iff can_issue and any req_valid. Then req_ready[winner]=1 and all other req_ready=0.
- If there is no grant, req_ready is all zero.
- port_sel = req_addr of winner when granting, else 5'd0.
- On a grant edge:
  - rsp_data <= (ZERO_R31 && addr==31) ? 0 : port_data
  - rsp_id <= winner; rsp_addr <= addr; rsp_valid <= 1
  - rr_ptr <= (winner+1) mod NREQ
- On a non-grant edge with can_issue: rsp_valid <= 0. rsp_data, rsp_id and rsp_addr hold.
- On an edge with !can_issue (stall): everything holds, and no req_ready is asserted.
- Requester contract: hold req_valid and req_addr stable until granted. The arbiter never drops a request without granting it.
- Fairness: a continuously valid requester is granted within NREQ grants.
- Reset (async, any time): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_addr=0, rr_ptr=0. An in-flight response is discarded; requesters must re-request.

## Timing
- Latency: a grant in cycle N gives rsp_valid=1 in cycle N+1.
- Throughput: one grant per cycle while rsp_ready=1, including back-to-back grants to the same requester when it is the only one valid.
- Simultaneous accept and issue: a response is accepted (rsp_ready=1) and a new grant issued in the same cycle. The register reloads with no bubble.
- req_ready and port_sel depend combinationally on req_valid, req_addr, rsp_valid, rsp_ready and rr_ptr. port_data is sampled only at the grant edge.
- All outputs are driven to their reset values while reset_n=0.

## Test plan
- Reset mid-stall:
  - Stimulus: rsp_valid=1, rsp_ready=0, assert reset_n=0 between edges.
  - Required: rsp_valid drops immediately, rr_ptr=0, and req_ready=0 while in reset.
- Single requester, model returns port_data = {59'b0, port_sel}:
  - Stimulus: req_valid=4'b0001, addr 5, rsp_ready=1.
  - Required: req_ready=0001 and port_sel=5. Next cycle rsp_valid=1, rsp_data=5, rsp_id=0, rsp_addr=5, then one response per cycle.
- Round-robin:
  - Stimulus: all four valid from reset, addrs 1/2/3/4, rsp_ready=1.
  - Required: grants in order 0,1,2,3,0. rsp_id sequence 0,1,2,3 on consecutive cycles.
- Backpressure:
  - Stimulus: req_valid=0011, rsp_ready=0 after the first grant.
  - Required: rsp holds id 0 data unchanged, req_ready=00 and no further grant. When rsp_ready=1 for one cycle, requester 1 is granted in that same cycle and rsp_id=1 appears next cycle.
- XZR:
  - Stimulus: ZERO_R31=1, request addr 31 with port_data=64'hDEAD_BEEF_0000_0001.
  - Required: rsp_data=0 and rsp_addr=31.
  - Repeat with ZERO_R31=0: required rsp_data=64'hDEAD_BEEF_0000_0001.
- Wrap and skip:
  - Stimulus: rr_ptr=3 after granting 2, req_valid=0101.
  - Required: grant 0 (skips invalid 3, wraps), then grant 2, then rr_ptr=3.
